mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter and sequencer for the single shared multicycle main memory behind the CPU's instruction and data caches. It takes miss/write requests from the I-cache (fetch stage) and D-cache (memory stage), grants one at a time, and drives the memory port. A grant runs either a full block fill (pipelined word reads) or a single-word write-through store. Returned words stream back to the granted cache with a word index and a completion pulse.

## Interface
Parameters:
- MEM_LAT, 4, fixed memory read latency in cycles, from issue (mem_en) to mem_rvalid; range 1..15.
- BLOCK_WORDS, 8, 16-bit words per cache block; power of two, range 2..16.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- i_req  in  1  I-cache block fill request; level signal, held until i_done.
- i_addr  in  16  I-miss byte address; stable while i_req is high.
- d_req  in  1  D-cache request; level signal, held until d_done.
- d_we  in  1  1 = single-word store, 0 = block fill; stable with d_req.
- d_addr  in  16  D byte address.
- d_wdata  in  16  store data.
- i_fill_valid / d_fill_valid  out  1  returned fill word valid this cycle.
- i_fill_word / d_fill_word  out  log2(BLOCK_WORDS)  index of the returned word.
- fill_data  out  16  returned word, shared by both sides.
- i_done / d_done  out  1  one-cycle completion pulse.
- mem_en  out  1  memory access issue.
- mem_wr  out  1  write qualifier for mem_en.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  store data.
- mem_rdata  in  16  read data.
- mem_rvalid  in  1  read data valid, exactly MEM_LAT cycles after the read issue.

## Operation
- States: IDLE, I_FILL, D_FILL, D_WRITE.
- IDLE: sample requests.
  - d_req alone: go to D_WRITE if d_we, else D_FILL.
  - i_req alone: go to I_FILL.
  - Both asserted: arbitrate (see Configuration).
- Fill states:
  - Issue counter runs 0..BLOCK_WORDS-1, one read per cycle.
  - mem_addr = {addr[15:OFS], issue_cnt, 1'b0}, where OFS = log2(BLOCK_WORDS)+1. Alignment is forced; the requester's low address bits are ignored.
  - Receive counter advances on each mem_rvalid.
  - x_fill_valid = mem_rvalid; x_fill_word = receive counter; fill_data = mem_rdata.
  - On the last received word, pulse x_done in the same cycle and go to IDLE.
- D_WRITE: one cycle with mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata, and d_done=1. Then go to IDLE.
- Requester contract: drop req in the cycle after its done pulse. The arbiter does not block re-arbitration in that cycle.
- mem_rvalid while in IDLE or D_WRITE (stale data after a reset) is ignored: no fill_valid.

## Timing
- Reset value of every output is 0: all valids and dones, mem_en, mem_wr, mem_addr, mem_wdata, fill_data, and word indices. State resets to IDLE; counters and the round-robin pointer are cleared.
- Request at cycle c in IDLE → grant state entered at c+1.
- Fill: issues at c+1..c+BLOCK_WORDS; data at c+1+MEM_LAT..c+BLOCK_WORDS+MEM_LAT; done coincides with the last word. Defaults: done at c+12, IDLE at c+13.
- Store: mem write and d_done at c+1, IDLE at c+2.
- A new request can be granted no earlier than one IDLE cycle after done (2-cycle turnaround).
- Reset asserted mid-operation: the next edge returns to IDLE with all outputs 0. The aborted requester sees no done pulse and must re-request.

## Configuration
- ARB_RR_EN defined: round-robin on ties.
  - A last_grant flop records the winner (I or D); on a tie, the side not granted last wins.
  - last_grant resets to I, so the first tie goes to D.
- ARB_RR_EN undefined: fixed priority; D always wins ties (older instruction in MEM). No last_grant flop.

## Structure
- Shared package mem_arb_pkg holds:
  - state enum (IDLE, I_FILL, D_FILL, D_WRITE);
  - MEM_LAT and BLOCK_WORDS defaults;
  - OFS derivation;
  - requester ID encoding (REQ_I=0, REQ_D=1).
- Sub-module fill_seq holds the issue/receive counters, address formation, and last-word detect. It is instantiated once and shared by I_FILL and D_FILL.

## Test plan
- I fill alone, i_addr=0x1234, req at cycle c:
  - mem_addr 0x1230..0x123E at c+1..c+8;
  - i_fill_word 0..7 at c+5..c+12 with data matching the memory model;
  - i_done=1 at c+12 only.
- D store, d_addr=0x0040, d_wdata=0xBEEF: at c+1, mem_en=1, mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, d_done=1; at c+2, all zero.
- i_req and d_req (fill) together at c:
  - D fill runs c+1..c+12;
  - i_req still high is granted at c+14, and i_done arrives at c+25;
  - no i_fill_valid during the D fill.
- Two consecutive ties after reset:
  - first tie goes to D;
  - second tie goes to I with ARB_RR_EN, and to D without it.
- rst_n low for one cycle after the 3rd issued word of an I fill:
  - next cycle state is IDLE with all outputs 0;
  - subsequent in-flight mem_rvalid pulses produce no i_fill_valid and no i_done.
- mem_rvalid=1 with mem_rdata=0xAAAA while in IDLE → no fill_valid on either side.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the I/D memory arbiter
package mem_arb_pkg;

  localparam int MEM_LAT_DEF     = 4;
  localparam int BLOCK_WORDS_DEF = 8;

  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} arb_state_t;

  typedef enum logic {REQ_I = 1'b0, REQ_D = 1'b1} req_id_t;

  // Byte offset width of a block: word index bits plus the byte-in-word bit.
  function automatic int ofsOf(input int blockWords);
    return $clog2(blockWords) + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_fill_seq.sv
// rtl/mem_arbiter_fill_seq.sv - block fill issue/receive counters and address formation
module fill_seq
  import mem_arb_pkg::*;
#(
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  localparam int WW  = $clog2(BLOCK_WORDS),
  localparam int OFS = ofsOf(BLOCK_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          active,
  input  logic [15:0]   baseAddr,
  input  logic          rvalid,
  output logic          issue,
  output logic [15:0]   addr,
  output logic [WW-1:0] recvWord,
  output logic          lastWord
);

  logic [WW:0]   issueCnt;
  logic [WW-1:0] recvCnt;
  logic          unusedLowBits;

  // Counters idle at zero so every fill starts from word 0.
  always_ff @(posedge clk) begin
    if (!rst_n || !active) begin
      issueCnt <= '0;
      recvCnt  <= '0;
    end else begin
      if (issue)  issueCnt <= issueCnt + 1'b1;
      if (rvalid) recvCnt  <= recvCnt + 1'b1;
    end
  end

  assign issue    = active && !issueCnt[WW];
  assign addr     = {baseAddr[15:OFS], issueCnt[WW-1:0], 1'b0};
  assign recvWord = recvCnt;
  assign lastWord = active && rvalid && (recvCnt == WW'(BLOCK_WORDS - 1));

  // Requester offset bits are ignored; block alignment is forced.
  assign unusedLowBits = ^baseAddr[OFS-1:0];

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache arbiter and sequencer for the shared main memory
// ARB_RR_EN selects round-robin tie breaking; otherwise the D side always wins ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT     = MEM_LAT_DEF,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  localparam int WW = $clog2(BLOCK_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [15:0]   i_addr,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [15:0]   d_addr,
  input  logic [15:0]   d_wdata,
  output logic          i_fill_valid,
  output logic          d_fill_valid,
  output logic [WW-1:0] i_fill_word,
  output logic [WW-1:0] d_fill_word,
  output logic [15:0]   fill_data,
  output logic          i_done,
  output logic          d_done,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [15:0]   mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata,
  input  logic          mem_rvalid
);

  if (MEM_LAT < 1 || MEM_LAT > 15 || BLOCK_WORDS < 2 || BLOCK_WORDS > 16 ||
      (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) begin : gBadParam
    $error("mem_arbiter: parameter out of range");
  end

  arb_state_t    state, nextState;
  logic          fillActive, grantD, tieWinD;
  logic          seqIssue, seqLast;
  logic [15:0]   seqAddr;
  logic [WW-1:0] seqWord;

  assign fillActive = (state == I_FILL) || (state == D_FILL);
  assign grantD     = d_req && (!i_req || tieWinD);

  fill_seq #(.BLOCK_WORDS(BLOCK_WORDS)) uFillSeq (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (fillActive),
    .baseAddr ((state == D_FILL) ? d_addr : i_addr),
    .rvalid   (fillActive && mem_rvalid),
    .issue    (seqIssue),
    .addr     (seqAddr),
    .recvWord (seqWord),
    .lastWord (seqLast)
  );

`ifdef ARB_RR_EN
  req_id_t lastGrant;

  always_ff @(posedge clk) begin
    if (!rst_n)
      lastGrant <= REQ_I;
    else if (state == IDLE && (i_req || d_req))
      lastGrant <= grantD ? REQ_D : REQ_I;
  end

  assign tieWinD = (lastGrant == REQ_I);
`else
  assign tieWinD = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState    = state;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    i_fill_word  = '0;
    d_fill_word  = '0;
    fill_data    = '0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state)
      IDLE: begin
        if (grantD)     nextState = d_we ? D_WRITE : D_FILL;
        else if (i_req) nextState = I_FILL;
      end
      I_FILL: begin
        mem_en       = seqIssue;
        mem_addr     = seqIssue ? seqAddr : '0;
        i_fill_valid = mem_rvalid;
        i_fill_word  = mem_rvalid ? seqWord : '0;
        fill_data    = mem_rvalid ? mem_rdata : '0;
        i_done       = seqLast;
        if (seqLast) nextState = IDLE;
      end
      D_FILL: begin
        mem_en       = seqIssue;
        mem_addr     = seqIssue ? seqAddr : '0;
        d_fill_valid = mem_rvalid;
        d_fill_word  = mem_rvalid ? seqWord : '0;
        fill_data    = mem_rvalid ? mem_rdata : '0;
        d_done       = seqLast;
        if (seqLast) nextState = IDLE;
      end
      D_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_done    = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int MEM_LAT = 4;
  localparam int BW      = 8;
  localparam int WW      = $clog2(BW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0]   i_addr = '0, d_addr = '0, d_wdata = '0;
  logic          i_fill_valid, d_fill_valid, i_done, d_done;
  logic [WW-1:0] i_fill_word, d_fill_word;
  logic [15:0]   fill_data, mem_addr, mem_wdata;
  logic          mem_en, mem_wr;
  logic [15:0]   mem_rdata = '0;
  logic          mem_rvalid = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .i_fill_word(i_fill_word), .d_fill_word(d_fill_word),
    .fill_data(fill_data), .i_done(i_done), .d_done(d_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  // Memory model: each read returns its word exactly MEM_LAT cycles after issue.
  typedef struct { int due; logic [15:0] data; } rd_t;
  rd_t rdQ[$];
  int  cyc = 0;
  bit  forceStale = 1'b0;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return (a * 16'd3) ^ 16'hC3A5;
  endfunction

  always @(negedge clk)
    if (mem_en === 1'b1 && mem_wr === 1'b0) rdQ.push_back('{cyc + MEM_LAT, memWord(mem_addr)});

  always @(posedge clk) begin
    #1;
    cyc++;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (rdQ.size() > 0 && rdQ[0].due == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rdQ[0].data;
      rdQ.delete(0);
    end
    if (forceStale) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 16'hAAAA;
    end
  end

  typedef struct packed {
    logic iv; logic [WW-1:0] iw; logic dv; logic [WW-1:0] dw; logic [15:0] fd;
    logic idn; logic ddn; logic en; logic wr; logic [15:0] addr; logic [15:0] wdata;
  } outs_t;

  // Expected outputs k cycles after a fill request is raised in IDLE.
  function automatic outs_t fillExp(input bit isD, input logic [15:0] base, input int k);
    outs_t e;
    logic [15:0] blk;
    int j;
    e   = '0;
    blk = base & ~16'(2 * BW - 1);
    if (k >= 1 && k <= BW) begin
      e.en   = 1'b1;
      e.addr = blk + 16'(2 * (k - 1));
    end
    j = k - MEM_LAT - 1;
    if (j >= 0 && j < BW) begin
      e.fd = memWord(blk + 16'(2 * j));
      if (isD) begin e.dv = 1'b1; e.dw = WW'(j); e.ddn = (j == BW - 1); end
      else     begin e.iv = 1'b1; e.iw = WW'(j); e.idn = (j == BW - 1); end
    end
    return e;
  endfunction

  function automatic outs_t storeExp(input logic [15:0] a, input logic [15:0] wd, input int k);
    outs_t e;
    e = '0;
    if (k == 1) begin
      e.en = 1'b1; e.wr = 1'b1; e.addr = a; e.wdata = wd; e.ddn = 1'b1;
    end
    return e;
  endfunction

  function automatic outs_t rawOuts();
    return '{i_fill_valid, i_fill_word, d_fill_valid, d_fill_word, fill_data,
             i_done, d_done, mem_en, mem_wr, mem_addr, mem_wdata};
  endfunction

  // Fields whose value only matters while qualified are read as zero otherwise.
  function automatic outs_t sample(input outs_t e);
    outs_t a;
    a = rawOuts();
    if (!e.iv) a.iw = '0;
    if (!e.dv) a.dw = '0;
    if (!(e.iv || e.dv)) a.fd = '0;
    if (!e.en) a.addr = '0;
    if (!e.wr) a.wdata = '0;
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    outs_t a;
    rst_n = 1'b0;
    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a = rawOuts();
      checks++;
      if (a !== '0) begin
        errors++;
        $display("FAIL reset_outputs k=%0d got %h want 0", k, a);
      end
      step();
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill(input bit isD, input logic [15:0] addr, input string name);
    outs_t e, a;
    if (isD) begin d_req = 1'b1; d_we = 1'b0; d_addr = addr; end
    else     begin i_req = 1'b1; i_addr = addr; end
    for (int k = 0; k <= BW + MEM_LAT + 1; k++) begin
      @(negedge clk);
      e = fillExp(isD, addr, k);
      a = sample(e);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s k=%0d got %h want %h", name, k, a, e);
      end
      step();
      if (k == BW + MEM_LAT) begin i_req = 1'b0; d_req = 1'b0; end
    end
  endtask

  task automatic test_store(input logic [15:0] addr, input logic [15:0] wd);
    outs_t e, a;
    d_req = 1'b1; d_we = 1'b1; d_addr = addr; d_wdata = wd;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      e = storeExp(addr, wd, k);
      a = sample(e);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL store k=%0d got %h want %h", k, a, e);
      end
      step();
      if (k == 1) begin d_req = 1'b0; d_we = 1'b0; end
    end
  endtask

  task automatic test_reset_mid();
    outs_t e, a;
    logic [15:0] ia;
    ia = 16'($urandom);
    i_req = 1'b1; i_addr = ia;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      e = (k <= 4) ? fillExp(1'b0, ia, k) : '0;
      a = sample(e);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL reset_mid k=%0d got %h want %h", k, a, e);
      end
      step();
      if (k == 3) begin rst_n = 1'b0; i_req = 1'b0; end
      if (k == 4) rst_n = 1'b1;
    end
  endtask

  task automatic test_tie_fill();
    outs_t e, a;
    logic [15:0] ia, da;
    ia = 16'($urandom); da = 16'($urandom);
    i_req = 1'b1; i_addr = ia; d_req = 1'b1; d_we = 1'b0; d_addr = da;
    for (int k = 0; k <= 26; k++) begin
      @(negedge clk);
      e = (k <= 13) ? fillExp(1'b1, da, k) : fillExp(1'b0, ia, k - 13);
      a = sample(e);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL tie_fill k=%0d got %h want %h", k, a, e);
      end
      step();
      if (k == 12) d_req = 1'b0;
      if (k == 25) i_req = 1'b0;
    end
  endtask

  task automatic test_stale();
    outs_t a;
    @(negedge clk);
    forceStale = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a = rawOuts();
      checks++;
      if (a.iv !== 1'b0 || a.dv !== 1'b0 || a.idn !== 1'b0 || a.ddn !== 1'b0) begin
        errors++;
        $display("FAIL stale_rvalid k=%0d got %h want no valid/done", k, a);
      end
    end
    forceStale = 1'b0;
    step();
    step();
  endtask

  task automatic test_rr_ties();
    outs_t e, a;
    logic [15:0] ia, da, dd;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ia = 16'($urandom); da = 16'($urandom); dd = 16'($urandom);
    i_req = 1'b1; i_addr = ia; d_req = 1'b1; d_we = 1'b1; d_addr = da; d_wdata = dd;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      e = storeExp(da, dd, k);
      a = sample(e);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL tie1 k=%0d got %h want %h", k, a, e);
      end
      step();
      if (k == 1) begin i_req = 1'b0; d_req = 1'b0; end
    end
    da = 16'($urandom); dd = 16'($urandom);
    i_req = 1'b1; d_req = 1'b1; d_addr = da; d_wdata = dd;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
`ifdef ARB_RR_EN
      e = (k <= 13) ? fillExp(1'b0, ia, k) : storeExp(da, dd, k - 13);
`else
      e = (k <= 2) ? storeExp(da, dd, k) : fillExp(1'b0, ia, k - 2);
`endif
      a = sample(e);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL tie2 k=%0d got %h want %h", k, a, e);
      end
      step();
`ifdef ARB_RR_EN
      if (k == 12) i_req = 1'b0;
      if (k == 14) d_req = 1'b0;
`else
      if (k == 1)  d_req = 1'b0;
      if (k == 14) i_req = 1'b0;
`endif
    end
    d_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill(1'b0, 16'h1234, "i_fill_1234");
    test_store(16'h0040, 16'hBEEF);
    for (int n = 0; n < 3; n++) begin
      test_fill(n[0], 16'($urandom), "fill_rand");
      test_store(16'($urandom), 16'($urandom));
    end
    test_reset_mid();
    test_tie_fill();
    test_stale();
    test_rr_ties();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
